// File: rtl/neuron_pkg.sv
// Shared definitions for the dense-layer neurons: FSM states, default data
// format and sizing helpers.
package neuron_pkg;

  typedef enum logic [1:0] {IDLE, MAC, BIAS, OUT} state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_SHIFT  = 8;

  function automatic int calc_n(input int size, input int lanes);
    return (size + lanes - 1) / lanes;
  endfunction

  function automatic int min_acc_w(input int data_w, input int size);
    return 2 * data_w + $clog2(size);
  endfunction

endpackage

// File: rtl/neuron_lane_sum.sv
// Combinational sum of LANES signed products, sign-extended to ACC_W.
// Lanes whose element number (base + lane) falls past INPUT_SIZE add nothing.
module neuron_lane_sum #(
  parameter int LANES      = 2,
  parameter int INPUT_SIZE = 16,
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 40,
  parameter int IDX_W      = 6
) (
  input  logic [LANES-1:0][DATA_W-1:0] a,
  input  logic [LANES-1:0][DATA_W-1:0] b,
  input  logic [IDX_W-1:0]             base,
  output logic signed [ACC_W-1:0]      sum
);

  logic signed [2*DATA_W-1:0] prod [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_prod
    assign prod[l] = $signed(a[l]) * $signed(b[l]);
  end

  always_comb begin
    sum = '0;
    for (int l = 0; l < LANES; l++) begin
      if (base + IDX_W'(l) < IDX_W'(INPUT_SIZE))
        sum = sum + ACC_W'(prod[l]);
    end
  end

endmodule

// File: rtl/neuron_mac_lanes.sv
// Multi-lane MAC neuron: N = ceil(INPUT_SIZE/LANES) accumulate cycles, then
// rescale + bias, then saturate / optional ReLU with a registered done pulse.
//
// state | meaning
// IDLE  | waiting for start; latches bias/relu_en, clears acc and index
// MAC   | adds LANES products per cycle, N cycles
// BIAS  | tmp = (acc >>> SHIFT) + bias
// OUT   | clip, ReLU, flags; done registered for the following cycle
module neuron_mac_lanes
  import neuron_pkg::*;
#(
  parameter int INPUT_SIZE = 16,
  parameter int LANES      = 2,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ACC_W      = 40,
  parameter int SHIFT      = DEF_SHIFT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                relu_en,
  input  logic [INPUT_SIZE-1:0][DATA_W-1:0]   inputs,
  input  logic [INPUT_SIZE-1:0][DATA_W-1:0]   weights,
  input  logic signed [DATA_W-1:0]            bias,
  output logic signed [DATA_W-1:0]            result,
  output logic                                done,
  output logic                                sat,
  output logic                                busy
);

  localparam int N     = calc_n(INPUT_SIZE, LANES);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int IDX_W = $clog2(INPUT_SIZE + LANES) + 1;
  localparam int SEL_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;

  localparam logic signed [ACC_W-1:0] RES_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] RES_MIN = ~RES_MAX;

  state_t state, state_nxt;

  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   tmp;
  logic signed [ACC_W-1:0]   lane_total;
  logic [IDX_W-1:0]          index;
  logic [CNT_W-1:0]          cnt;
  logic signed [DATA_W-1:0]  bias_q;
  logic                      relu_q;
  logic signed [DATA_W-1:0]  clip_c;
  logic signed [DATA_W-1:0]  res_c;
  logic                      sat_c;

  logic [LANES-1:0][DATA_W-1:0] lane_a;
  logic [LANES-1:0][DATA_W-1:0] lane_b;

  // Keep the element select legal; the lane sum does the real masking.
  for (genvar l = 0; l < LANES; l++) begin : g_sel
    logic [IDX_W-1:0] elem;
    logic [SEL_W-1:0] sel;
    assign elem      = index + IDX_W'(l);
    assign sel       = (elem < IDX_W'(INPUT_SIZE)) ? elem[SEL_W-1:0] : '0;
    assign lane_a[l] = inputs[sel];
    assign lane_b[l] = weights[sel];
  end

  neuron_lane_sum #(
    .LANES      (LANES),
    .INPUT_SIZE (INPUT_SIZE),
    .DATA_W     (DATA_W),
    .ACC_W      (ACC_W),
    .IDX_W      (IDX_W)
  ) u_lane_sum (
    .a    (lane_a),
    .b    (lane_b),
    .base (index),
    .sum  (lane_total)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MAC;
      MAC:     if (cnt == '0) state_nxt = BIAS;
      BIAS:    state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sat_c  = 1'b0;
    clip_c = tmp[DATA_W-1:0];
    if (tmp > RES_MAX) begin
      clip_c = RES_MAX[DATA_W-1:0];
      sat_c  = 1'b1;
    end else if (tmp < RES_MIN) begin
      clip_c = RES_MIN[DATA_W-1:0];
      sat_c  = 1'b1;
    end
    res_c = (relu_q && clip_c[DATA_W-1]) ? '0 : clip_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      tmp    <= '0;
      index  <= '0;
      cnt    <= '0;
      bias_q <= '0;
      relu_q <= 1'b0;
      result <= '0;
      sat    <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state != IDLE);
      case (state)
        IDLE: if (start) begin
          acc    <= '0;
          index  <= '0;
          cnt    <= CNT_W'(N - 1);
          bias_q <= bias;
          relu_q <= relu_en;
        end
        MAC: begin
          acc   <= acc + lane_total;
          index <= index + IDX_W'(LANES);
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        BIAS: tmp <= (acc >>> SHIFT) + ACC_W'(bias_q);
        OUT: begin
          result <= res_c;
          sat    <= sat_c;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_lanes.sv
// Bench for neuron_mac_lanes: a 16-input/2-lane instance and a 5-input/2-lane
// instance, vector table plus handshake and mid-operation reset sequences.
module tb_neuron_mac_lanes;
  import neuron_pkg::*;

  typedef struct {
    bit odd;
    bit ramp;
    bit single;
    int in_v;
    int w_v;
    int bias;
    bit relu;
    int exp_res;
    bit exp_sat;
  } vec_t;

  typedef struct {
    logic signed [15:0] res;
    bit                 sat;
  } exp_t;

  logic clk, rst;

  logic                start16, relu16, done16, sat16, busy16;
  logic [15:0][15:0]   in16, w16;
  logic signed [15:0]  bias16, result16;

  logic                start5, relu5, done5, sat5, busy5;
  logic [4:0][15:0]    in5, w5;
  logic signed [15:0]  bias5, result5;

  int total = 0;
  int bad   = 0;
  int dcnt16 = 0;
  int dcnt5  = 0;
  exp_t q16[$];
  exp_t q5[$];
  exp_t e16, e5;
  vec_t vecs[15];

  neuron_mac_lanes #(
    .INPUT_SIZE(16), .LANES(2), .DATA_W(16), .ACC_W(40), .SHIFT(8)
  ) dut16 (
    .clk(clk), .rst(rst), .start(start16), .relu_en(relu16),
    .inputs(in16), .weights(w16), .bias(bias16),
    .result(result16), .done(done16), .sat(sat16), .busy(busy16)
  );

  neuron_mac_lanes #(
    .INPUT_SIZE(5), .LANES(2), .DATA_W(16), .ACC_W(min_acc_w(16, 5)), .SHIFT(8)
  ) dut5 (
    .clk(clk), .rst(rst), .start(start5), .relu_en(relu5),
    .inputs(in5), .weights(w5), .bias(bias5),
    .result(result5), .done(done5), .sat(sat5), .busy(busy5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Scoreboard side: every done pops one expected record.
  always @(posedge clk) begin
    #2;
    if (done16) begin
      dcnt16++;
      if (q16.size() == 0) check("done16_unexpected", 1, 0);
      else begin
        e16 = q16.pop_front();
        check("result16", result16, e16.res);
        check("sat16", sat16, e16.sat);
      end
    end
    if (done5) begin
      dcnt5++;
      if (q5.size() == 0) check("done5_unexpected", 1, 0);
      else begin
        e5 = q5.pop_front();
        check("result5", result5, e5.res);
        check("sat5", sat5, e5.sat);
      end
    end
  end

  task automatic drive(input vec_t v);
    if (v.odd) begin
      for (int i = 0; i < 5; i++) begin
        in5[i] = 16'((v.single && i != 0) ? 0 : (v.ramp ? v.in_v * (i + 1) : v.in_v));
        w5[i]  = 16'((v.single && i != 0) ? 0 : v.w_v);
      end
      bias5 = 16'(v.bias);
      relu5 = v.relu;
    end else begin
      for (int i = 0; i < 16; i++) begin
        in16[i] = 16'((v.single && i != 0) ? 0 : (v.ramp ? v.in_v * (i + 1) : v.in_v));
        w16[i]  = 16'((v.single && i != 0) ? 0 : v.w_v);
      end
      bias16 = 16'(v.bias);
      relu16 = v.relu;
    end
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.res = 16'(v.exp_res);
    e.sat = v.exp_sat;
    if (v.odd) q5.push_back(e);
    else       q16.push_back(e);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int  lat, cyc, bcnt;
    bit  seen;
    logic b, d, r_sat;
    logic signed [15:0] r;
    lat = v.odd ? 5 : 10;
    drive(v);
    push_exp(v);
    if (v.odd) start5 = 1'b1;
    else       start16 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0;
    start16 = 1'b0;
    cyc = 0; bcnt = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      b = v.odd ? busy5 : busy16;
      d = v.odd ? done5 : done16;
      if (b) bcnt++;
      if (d) seen = 1'b1;
    end
    check($sformatf("%s_latency", tag), seen ? cyc : -1, lat);
    check($sformatf("%s_busy_cycles", tag), bcnt, lat);
    @(posedge clk); #1;
    d = v.odd ? done5 : done16;
    b = v.odd ? busy5 : busy16;
    r = v.odd ? result5 : result16;
    r_sat = v.odd ? sat5 : sat16;
    check($sformatf("%s_done_single", tag), d, 0);
    check($sformatf("%s_busy_after", tag), b, 0);
    check($sformatf("%s_result_hold", tag), r, v.exp_res);
    check($sformatf("%s_sat_hold", tag), r_sat, v.exp_sat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, nd, cyc;

    //         odd ramp sgl  in      w       bias    relu res     sat
    vecs[0]  = '{0, 0, 0,   256,    256,    0,      0,   4096,   0};
    vecs[1]  = '{0, 0, 0,   32767,  32767,  0,      0,   32767,  1};
    vecs[2]  = '{0, 0, 0,   32767, -32768,  0,      0,  -32768,  1};
    vecs[3]  = '{0, 0, 0,   256,   -256,    100,    0,  -3996,   0};
    vecs[4]  = '{0, 0, 0,   256,   -256,    100,    1,   0,      0};
    vecs[5]  = '{0, 0, 1,   1,     -1,      0,      0,  -1,      0};
    vecs[6]  = '{0, 0, 1,   3,      100,    0,      0,   1,      0};
    vecs[7]  = '{0, 0, 1,  -3,      100,    0,      0,  -2,      0};
    vecs[8]  = '{0, 0, 0,   32767, -32768,  0,      1,   0,      1};
    vecs[9]  = '{0, 0, 0,   100,    100,    50,     1,   675,    0};
    vecs[10] = '{0, 0, 0,   0,      0,     -32768,  0,  -32768,  0};
    vecs[11] = '{0, 0, 0,   0,      0,      32767,  0,   32767,  0};
    vecs[12] = '{1, 1, 0,   1,      512,   -10,     0,   20,     0};
    vecs[13] = '{1, 1, 0,   1,      512,   -100,    1,   0,      0};
    vecs[14] = '{1, 1, 0,  -1,      512,   -10,     0,  -40,     0};

    rst = 1'b1;
    start16 = 1'b0; relu16 = 1'b0; bias16 = '0; in16 = '0; w16 = '0;
    start5  = 1'b0; relu5  = 1'b0; bias5  = '0; in5  = '0; w5  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result16", result16, 0);
    check("reset_done16", done16, 0);
    check("reset_sat16", sat16, 0);
    check("reset_busy16", busy16, 0);
    check("reset_busy5", busy5, 0);
    check("reset_done5", done5, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 15; k++)
      run_vec($sformatf("vec%0d", k), vecs[k]);

    // start pulses while MAC is running must not spawn extra computations
    drive(vecs[3]);
    push_exp(vecs[3]);
    base = dcnt16;
    start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      start16 = (c >= 2 && c <= 5);
    end
    start16 = 1'b0;
    check("ignored_start_done_count", dcnt16 - base, 1);

    // start held high: accepts at 0, 11, 22 -> done at 10, 21, 32
    drive(vecs[9]);
    for (int k = 0; k < 3; k++) push_exp(vecs[9]);
    start16 = 1'b1;
    @(posedge clk); #1;
    nd = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 22) start16 = 1'b0;
      if (done16) begin
        if (nd < 3) check($sformatf("held_done%0d_cycle", nd), c, 10 + 11 * nd);
        nd++;
      end
    end
    check("held_done_count", nd, 3);

    // abort mid-MAC while index is 4, with a saturated result on the outputs
    run_vec("pre_abort", vecs[2]);
    drive(vecs[0]);
    start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    cyc = 0;
    repeat (2) begin
      @(posedge clk); #1;
      cyc++;
    end
    rst = 1'b1;
    #1;
    check("abort_busy", busy16, 0);
    check("abort_done", done16, 0);
    check("abort_sat", sat16, 0);
    check("abort_result", result16, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_done", done16, 0);
    run_vec("post_abort", vecs[0]);

    repeat (3) @(posedge clk);
    #1;
    check("q16_drained", q16.size(), 0);
    check("q5_drained", q5.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neuron_mac_lanes.md
Name: neuron_mac_lanes

Overview:
- Parametrised successor to the serial single-MAC neuron, used in dense layers of the quantized MNIST network.
- Each cycle it computes LANES products in parallel.
- Accumulator width, fixed-point shift and data width are parameters.
- Adds run-time selectable ReLU, a saturation flag and a busy/done handshake with a fixed, documented latency.

Parameters:
- INPUT_SIZE, 16: number of input/weight pairs.
- LANES, 2: products summed per MAC cycle. Range 1..INPUT_SIZE.
- DATA_W, 16: signed width of inputs, weights, bias and result.
- ACC_W, 40: signed accumulator width. Must be at least 2*DATA_W + clog2(INPUT_SIZE).
- SHIFT, 8: arithmetic right shift applied to the accumulator before the bias add (fixed-point rescale).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a computation. Sampled only in IDLE.
- relu_en  in  1  when 1, negative results are clamped to 0. Captured at start acceptance.
- inputs  in  DATA_W x INPUT_SIZE  signed activations. Must be held stable while busy=1.
- weights  in  DATA_W x INPUT_SIZE  signed weights. Must be held stable while busy=1.
- bias  in  DATA_W  signed bias. Captured at start acceptance.
- result  out  DATA_W  signed saturated output. Holds its value until the next done.
- done  out  1  single-cycle pulse; result is valid in that same cycle.
- sat  out  1  1 when the current result was clipped by saturation. Updated with done and held.
- busy  out  1  high from the cycle after start acceptance until the cycle done is asserted (inclusive).

Behaviour:
- Reset (async, rst=1): state=IDLE; acc, index, result = 0; done, sat, busy = 0.
- Define N = ceil(INPUT_SIZE/LANES).
- States and transitions:
  - IDLE: if start=1, go to MAC. Latch bias and relu_en; clear acc and index.
  - MAC: add the sum of lane products for elements index..index+LANES-1 to acc. Lanes with element number >= INPUT_SIZE contribute 0. Increment index by LANES. After N MAC cycles go to BIAS.
  - BIAS: tmp = (acc >>> SHIFT) + sign-extended bias. Width is ACC_W. The shift is floor-arithmetic, with no rounding. Go to OUT.
  - OUT: compute result and flags, assert done=1 for this cycle only, go to IDLE.
- OUT result rules:
  - result = clip(tmp) to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - sat = 1 if clipping occurred.
  - If relu_en=1 and the clipped value is < 0, then result = 0. sat reflects clipping only; ReLU alone does not set sat.
- Latency: start sampled at edge T. done=1 in the cycle after edge T+N+2; result is valid in that cycle. Total latency N+2 cycles. busy=1 from T+1 through the done cycle.
- start while busy=1 is ignored. It is not queued.
- start high in the done cycle is ignored (state is OUT). It is accepted on the next IDLE cycle.
- start held high continuously gives back-to-back computations every N+3 cycles.
- Products are DATA_W x DATA_W signed giving 2*DATA_W bits, sign-extended to ACC_W before summation. With the minimum ACC_W the accumulator cannot overflow, so no internal wrap-around occurs.
- Reset mid-operation: abort immediately to IDLE. No done pulse; result and sat return to 0.

Decomposition:
- Shared package neuron_pkg:
  - typedef of the state enum {IDLE, MAC, BIAS, OUT};
  - localparam helper functions for N and the minimum ACC_W;
  - default DATA_W=16 and SHIFT=8 constants, shared with the other layer neurons.
- One sub-module: neuron_lane_sum. Combinational. Takes LANES operand pairs plus a base index and returns their signed ACC_W sum, including the zero-masking of out-of-range lanes.
- The FSM, saturation and ReLU stay in the top module.

Test Plan:
- Basic: INPUT_SIZE=16, LANES=2; all inputs=256, weights=256, bias=0, relu_en=0; start pulse → done exactly 10 cycles later, result=4096, sat=0, busy high for 10 cycles.
- Saturation: all inputs=32767, weights=32767, bias=0 → result=32767, sat=1. Then all weights=-32768 with inputs=32767 → result=-32768, sat=1.
- ReLU and floor shift:
  - inputs=256, weights=-256, bias=100, relu_en=0 → result=-3996;
  - repeat with relu_en=1 → result=0, sat=0;
  - single element 1*(-1), rest 0, bias=0, relu_en=0 → result=-1 (floor).
- Odd size: INPUT_SIZE=5, LANES=2; inputs 1..5, weights all 512, bias=-10 → N=3, done 5 cycles after start, result=(15*512>>>8)-10=20.
- Handshake: start re-asserted during MAC cycles → ignored, exactly one done. start held high → done pulses every N+3 cycles with a correct result each time.
- Reset mid-op: assert rst during the MAC cycle in which index=4 → busy, done, sat, result go to 0 asynchronously. After release, a new start gives the correct result with standard latency.
